instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   Fetch sequencer for the combinational instruction memory (InstructionMem).
//   Owns the program counter, drives the memory address, and buffers the
//   {pc, instruction} pairs in a small queue toward decode with a valid/ready handshake.
//   Handles branch/jump redirects, halts on an all-zero word, and faults on a misaligned target.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded at reset
//   FIFO_DEPTH  2              fetch queue entries (power of 2, >=2)
// PORTS
//   clk             in   1   single clock; all state updates on rising edge
//   rst_n           in   1   synchronous, active-low reset
//   fetch_en        in   1   1 = fetching permitted; 0 = hold PC, queue keeps draining
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  redirect target
//   imem_addr       out  32  = pc register (word aligned); memory decodes [7:2]
//   imem_rdata      in   32  combinational instruction word for imem_addr
//   out_valid       out  1   queue head valid
//   out_ready       in   1   decode accepts head when out_valid & out_ready
//   out_instr       out  32  head instruction
//   out_pc          out  32  head PC
//   halted          out  1   fetch stopped on an all-zero word
//   fetch_fault     out  1   fetch stopped on a misaligned redirect
// BEHAVIOUR
//   Reset (rst_n=0 at edge): pc=RESET_PC, queue empty, state=S_RUN, out_valid=0,
//     out_instr=0, out_pc=0, halted=0, fetch_fault=0. Reset mid-operation discards everything.
//   States: S_RUN, S_HALT, S_FAULT. Outputs halted=(S_HALT), fetch_fault=(S_FAULT), both registered.
//   Push condition (S_RUN, fetch_en=1, no redirect, space): space = !full | pop.
//     Push {pc, imem_rdata}; pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//   Zero word: in S_RUN with fetch_en=1 and no redirect, imem_rdata==0 is not pushed;
//     pc holds; next state S_HALT. The queue continues draining.
//   Pop: out_valid & out_ready removes the head. Push and pop can occur together when full.
//   Redirect (highest priority, any state): queue flushed (a same-cycle pop still counts
//     as delivered); no push that cycle.
//     redirect_pc[1:0]==0 -> pc <= redirect_pc, state S_RUN.
//     otherwise -> pc unchanged, state S_FAULT.
//   S_HALT and S_FAULT are left only via an aligned redirect or reset.
//   fetch_en=0: no push, pc holds, state unchanged; redirect is still honoured.
//   Latency: a push at edge N makes out_valid=1 in the cycle after edge N.
//     Example: redirect in cycle N -> out_valid=1, out_pc=redirect_pc in cycle N+2.
//     After reset release with fetch_en=1: first push in cycle 0, out_valid=1 in cycle 1.
//   Throughput: with out_ready held at 1, one instruction per cycle.
//   out_* are driven directly from the queue head registers (no combinational path from
//     imem_rdata). While out_valid=0, out_instr and out_pc hold their last value.
// STRUCTURE
//   Package fetch_pkg: state enum {S_RUN, S_HALT, S_FAULT}, PC_STEP=32'd4,
//     HALT_WORD=32'h0000_0000, fetch entry struct {pc[31:0], instr[31:0]}.
//   Sub-module fetch_fifo: FIFO_DEPTH-deep sync FIFO with push, pop, flush, full, empty.
//     flush overrides push and pop.
//   Top level: pc register, FSM and push/redirect logic.
// TESTING
//   1. Reset, fetch_en=1, out_ready=1, ROM word0=0x00000013 -> cycle 1: out_valid=1,
//      out_pc=0, out_instr=0x00000013; then out_pc 4, 8, ... one per cycle.
//   2. out_ready=0 for 5 cycles -> queue fills with PCs 0,4; pc holds at 8; no overwrite.
//      Release -> PCs 0,4,8 delivered in order with no gap or duplicate.
//   3. Redirect in cycle N with redirect_pc=0x1C while queue is full ->
//      flushed; cycle N+1 out_valid=0; cycle N+2 out_pc=0x1C, out_instr=0xFE5FF06F.
//   4. Fetch reaches PC 0x30 (outside the ROM, returns 0) -> halted=1, pc stays 0x30,
//      queued words drain; then redirect to 0x0 -> halted=0, fetch resumes at 0.
//   5. Redirect to 0x22 -> fetch_fault=1, queue empty, no pushes;
//      redirect to 0x20 -> fault clears, out_pc=0x20 two cycles later.
//   6. rst_n=0 for one cycle while the queue is full and pc=0x14 -> next cycle
//      out_valid=0, pc=RESET_PC, flags clear; fetch_en toggling holds pc without loss.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register fetch queue; the head always sits in slot 0 so it can drive
// decode straight from a register and keeps its last value once drained.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    fetch_entry_t  r_mem [DEPTH];
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_wr_cnt;
    logic [AW-1:0] w_wr_idx;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[0];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // The write slot is counted after this cycle's pop has shifted the queue down.
    always_comb begin
        w_wr_cnt = w_pop ? (r_count - ONE_CNT) : r_count;
        w_wr_idx = w_wr_cnt[AW-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if ((i + 1) < int'(r_count)) begin
                        r_mem[i] <= r_mem[i+1];
                    end
                end
            end
            if (w_push) begin
                r_mem[w_wr_idx] <= i_data;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory and
// queues {pc, instr} pairs toward decode; handles redirects, halt and fault.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_en,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    output logic        o_halted,
    output logic        o_fetch_fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;

    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_full;
    logic         w_empty;
    logic         w_space;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    assign o_imem_addr   = r_pc;
    assign o_out_valid   = ~w_empty;
    assign o_out_pc      = w_head.pc;
    assign o_out_instr   = w_head.instr;
    assign o_halted      = (r_state == S_HALT);
    assign o_fetch_fault = (r_state == S_FAULT);

    assign w_pop             = o_out_valid & i_out_ready;
    assign w_space           = ~w_full | w_pop;
    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = i_imem_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // A redirect wins over everything; a same-cycle pop has still been delivered.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        if (i_redirect_valid) begin
            w_flush = 1'b1;
            if (is_word_aligned(i_redirect_pc)) begin
                w_pc_next    = i_redirect_pc;
                w_state_next = S_RUN;
            end else begin
                w_state_next = S_FAULT;
            end
        end else if ((r_state == S_RUN) && i_fetch_en) begin
            if (i_imem_rdata == HALT_WORD) begin
                w_state_next = S_HALT;
            end else if (w_space) begin
                w_push    = 1'b1;
                w_pc_next = r_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(w_flush),
        .i_data (w_push_data),
        .o_head (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model of the fetch rules.
module tb_instr_fetch_ctrl;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] rom [64];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;
    bit          m_halted;
    bit          m_faulted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr[7:2]];

    instr_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_fetch_en      (fetch_en),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_instr     (out_instr),
        .o_out_pc        (out_pc),
        .o_halted        (halted),
        .o_fetch_fault   (fetch_fault)
    );

    // Reference model: advances one clock edge using the currently driven inputs.
    task automatic model_step();
        ent_t e;
        if (!rst_n) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_halted = 1'b0;
            m_faulted = 1'b0;
            m_last_pc = 32'h0;
            m_last_instr = 32'h0;
            return;
        end
        if (m_q.size() > 0) begin
            m_last_pc = m_q[0].pc;
            m_last_instr = m_q[0].instr;
            if (out_ready) void'(m_q.pop_front());
        end
        if (redirect_valid) begin
            m_q.delete();
            m_halted = 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                m_pc = redirect_pc;
                m_faulted = 1'b0;
            end else begin
                m_faulted = 1'b1;
            end
        end else if (!m_halted && !m_faulted && fetch_en) begin
            if (rom[m_pc[7:2]] == 32'h0) begin
                m_halted = 1'b1;
            end else if (m_q.size() < DEPTH) begin
                e.pc = m_pc;
                e.instr = rom[m_pc[7:2]];
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic bit exp_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (m_q.size() != 0) ? m_q[0].pc : m_last_pc;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (m_q.size() != 0) ? m_q[0].instr : m_last_instr;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", out_instr); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
        checks++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %0b%0b want 00", halted, fetch_fault); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== rom[k]) begin
                errors++;
                $display("[TB] FAIL stream_%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h", k, out_valid, out_pc, out_instr, 32'(4 * k), rom[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head got v=%0b pc=%h want v=1 pc=0", out_valid, out_pc); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_pc_hold got %h want 8", imem_addr); end
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL bp_drain_%0d got v=%0b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h1C;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush got v=%0b want 0", out_valid); end
        checks++; if (out_pc !== 32'hC) begin errors++; $display("[TB] FAIL redir_hold_pc got %h want c", out_pc); end
        checks++; if (imem_addr !== 32'h1C) begin errors++; $display("[TB] FAIL redir_addr got %h want 1c", imem_addr); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1C || out_instr !== 32'hFE5F_F06F) begin
            errors++;
            $display("[TB] FAIL redir_first got v=%0b pc=%h ins=%h want v=1 pc=1c ins=fe5ff06f", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_halt();
        bit seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (halted) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL halt_timeout got halted=0 want 1 within 16 cycles"); end
        checks++; if (imem_addr !== 32'h30) begin errors++; $display("[TB] FAIL halt_pc got %h want 30", imem_addr); end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h2C || out_instr !== rom[11] || halted !== 1'b1 || imem_addr !== 32'h30) begin
            errors++;
            $display("[TB] FAIL halt_drain got v=%0b pc=%h ins=%h h=%0b a=%h want v=0 pc=2c ins=%h h=1 a=30", out_valid, out_pc, out_instr, halted, imem_addr, rom[11]);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL halt_exit got h=%0b a=%h want h=0 a=0", halted, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h13) begin errors++; $display("[TB] FAIL halt_resume got v=%0b pc=%h ins=%h want v=1 pc=0 ins=13", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h4) begin
                errors++;
                $display("[TB] FAIL fault_hold_%0d got f=%0b v=%0b a=%h want f=1 v=0 a=4", k, fetch_fault, out_valid, imem_addr);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h20 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_exit got f=%0b a=%h v=%0b want f=0 a=20 v=0", fetch_fault, imem_addr, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== rom[8]) begin errors++; $display("[TB] FAIL fault_resume got v=%0b pc=%h ins=%h want v=1 pc=20 ins=%h", out_valid, out_pc, out_instr, rom[8]); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        checks++; if (imem_addr !== 32'h0 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc got a=%h pc=%h want a=0 pc=fffffffc", imem_addr, out_pc); end
        tick();
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h13) begin errors++; $display("[TB] FAIL wrap_fetch got pc=%h ins=%h want pc=0 ins=13", out_pc, out_instr); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hC;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        checks++; if (imem_addr !== 32'h14 || out_valid !== 1'b1 || out_pc !== 32'hC) begin errors++; $display("[TB] FAIL rstmid_setup got a=%h v=%0b pc=%h want a=14 v=1 pc=c", imem_addr, out_valid, out_pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== RESET_PC || out_pc !== 32'h0 || halted !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear got v=%0b a=%h pc=%h h=%0b f=%0b want v=0 a=%h pc=0 h=0 f=0", out_valid, imem_addr, out_pc, halted, fetch_fault, RESET_PC);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            fetch_en = ($urandom_range(0, 1) == 1);
            tick();
            checks++;
            if (out_valid !== exp_valid() || out_pc !== exp_pc() || imem_addr !== m_pc) begin
                errors++;
                $display("[TB] FAIL rstmid_toggle_%0d got v=%0b pc=%h a=%h want v=%0b pc=%h a=%h", k, out_valid, out_pc, imem_addr, exp_valid(), exp_pc(), m_pc);
            end
        end
        fetch_en = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst_n          = ($urandom_range(0, 127) != 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = {28'h0, 4'($urandom_range(0, 15)) | 4'h1} & 32'h3F;
                1:       redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            endcase
            tick();
            checks++;
            if (out_valid !== exp_valid()) begin errors++; $display("[TB] FAIL rand_valid_%0d got %0b want %0b", k, out_valid, exp_valid()); end
            checks++;
            if (out_pc !== exp_pc() || out_instr !== exp_instr()) begin errors++; $display("[TB] FAIL rand_head_%0d got pc=%h ins=%h want pc=%h ins=%h", k, out_pc, out_instr, exp_pc(), exp_instr()); end
            checks++;
            if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rand_addr_%0d got %h want %h", k, imem_addr, m_pc); end
            checks++;
            if (halted !== m_halted || fetch_fault !== m_faulted) begin errors++; $display("[TB] FAIL rand_flags_%0d got h=%0b f=%0b want h=%0b f=%0b", k, halted, fetch_fault, m_halted, m_faulted); end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        for (int i = 0; i < 12; i++) rom[i] = 32'h0000_0093 | (32'(i) << 20);
        rom[0]  = 32'h0000_0013;
        rom[7]  = 32'hFE5F_F06F;
        rom[62] = 32'h0040_0113;
        rom[63] = 32'h0080_0193;
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_halt();
        test_fault();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
